// File: rtl/sc_fir_pkg.sv
// Shared types, default geometry/coefficients and helpers for the stochastic FIR engine.
// The SC_FIR_LFSR_EN build option (used in sc_vdc_rng) relies on lfsr_taps() from here.
package sc_fir_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int DEF_N     = 12;
    localparam int DEF_ORDER = 18;

    typedef logic [DEF_N:0] cum_t;

    // Default filter: equal-weight moving average, cumulative weights rounded to 2^N.
    function automatic logic [DEF_ORDER:0][DEF_N:0] default_cum();
        logic [DEF_ORDER:0][DEF_N:0] v;
        for (int k = 0; k <= DEF_ORDER; k++) begin
            v[k] = cum_t'(((k + 1) * (1 << DEF_N) + (DEF_ORDER + 1) / 2) / (DEF_ORDER + 1));
        end
        return v;
    endfunction

    localparam logic [DEF_ORDER:0][DEF_N:0] COEF_CUM = default_cum();
    localparam logic [DEF_ORDER:0]          COEF_NEG = '0;

    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = v[w-1-i];
        end
        return r;
    endfunction

    // Fibonacci feedback masks (bit i = register bit i) for maximal-length sequences.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            default: return 32'h0000_D008;
        endcase
    endfunction

endpackage

// File: rtl/sc_vdc_rng.sv
// SC cycle counter plus comparator random source: bit-reversed count (van der Corput),
// or an N-bit maximal LFSR when SC_FIR_LFSR_EN is defined. start restarts the sequence.
module sc_vdc_rng
    import sc_fir_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk_i,
    input  logic         srst_i,
    input  logic         start_i,
    input  logic         run_i,
    output logic [N-1:0] cnt_o,
    output logic [N-1:0] r_o,
    output logic         last_o
);

    logic [N-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + N'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = run_i && (cnt_q == '1);

`ifdef SC_FIR_LFSR_EN
    localparam logic [N-1:0] TAPS = N'(lfsr_taps(N));

    logic [N-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (start_i) begin
            lfsr_d = N'(1);
        end else if (run_i) begin
            lfsr_d = {lfsr_q[N-2:0], ^(lfsr_q & TAPS)};
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            lfsr_q <= N'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign r_o = lfsr_q;
`else
    assign r_o = N'(bitrev(32'(cnt_q), N));
`endif

endmodule

// File: rtl/sc_fir_engine.sv
// Stochastic-computing FIR: each accepted sample shifts the tap line, then 2^N SC cycles
// count stream ones into the result. SC_FIR_LFSR_EN selects an LFSR comparator source.
module sc_fir_engine #(
    parameter int                                N        = sc_fir_pkg::DEF_N,
    parameter int                                ORDER    = sc_fir_pkg::DEF_ORDER,
    parameter logic [ORDER:0][N:0]               COEF_CUM = sc_fir_pkg::COEF_CUM,
    parameter logic [ORDER:0]                    COEF_NEG = sc_fir_pkg::COEF_NEG
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         done
);
    import sc_fir_pkg::*;

    localparam int IDX_W = (ORDER > 0) ? $clog2(ORDER + 1) : 1;

    state_e                  state_q, state_d;
    logic [ORDER:0][N-1:0]   taps_q;
    logic [N-1:0]            acc_q, acc_d;
    logic [N-1:0]            out_q, out_d;
    logic                    out_valid_q, out_valid_d;

    logic [N-1:0]            cnt, r_val;
    logic                    last, run, accept, in_ready_c, done_c;
    logic [ORDER:0]          hit;
    logic [IDX_W-1:0]        tsel;
    logic [N-1:0]            x_val, acc_sum;
    logic                    sc_bit;

    sc_vdc_rng #(.N(N)) u_rng (
        .clk_i   (clock),
        .srst_i  (reset),
        .start_i (accept),
        .run_i   (run),
        .cnt_o   (cnt),
        .r_o     (r_val),
        .last_o  (last)
    );

    // Inverse-CDF tap select: tap k owns sel in [COEF_CUM[k-1], COEF_CUM[k]).
    for (genvar gi = 0; gi <= ORDER; gi++) begin : g_cdf
        assign hit[gi] = ({1'b0, cnt} < COEF_CUM[gi]);
    end

    always_comb begin
        tsel = IDX_W'(ORDER);
        for (int k = ORDER; k >= 0; k--) begin
            if (hit[k]) begin
                tsel = IDX_W'(k);
            end
        end
    end

    assign x_val   = taps_q[tsel] ^ {N{COEF_NEG[tsel]}};
    assign sc_bit  = (x_val > r_val);
    assign acc_sum = acc_q + N'(sc_bit);

    assign in_ready = in_ready_c & ~reset;
    assign done     = done_c & ~reset;
    assign accept   = in_ready & in_valid;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        in_ready_c  = 1'b0;
        done_c      = 1'b0;
        run         = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                run   = 1'b1;
                acc_d = acc_sum;
                if (last) begin
                    done_c      = 1'b1;
                    out_d       = acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            taps_q      <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                taps_q <= {taps_q[ORDER-1:0], in};
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sc_fir_engine.sv
// Bench for sc_fir_engine (N=4, ORDER=1): vector table, reset-abort sequence and random samples
// against an arithmetic reference; two instances differ only in tap sign.
module tb_sc_fir_engine;

    localparam int N     = 4;
    localparam int ORDER = 1;
    localparam logic [ORDER:0][N:0] CUM = {5'd16, 5'd8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [N-1:0] din;

    logic         in_ready_a, out_valid_a, done_a;
    logic [N-1:0] out_a;
    logic         in_ready_b, out_valid_b, done_b;
    logic [N-1:0] out_b;

    sc_fir_engine #(.N(N), .ORDER(ORDER), .COEF_CUM(CUM), .COEF_NEG(2'b00)) dut_a (
        .clock(clk), .reset(rst), .in(din), .in_valid(in_valid), .in_ready(in_ready_a),
        .out(out_a), .out_valid(out_valid_a), .out_ready(out_ready), .done(done_a)
    );

    sc_fir_engine #(.N(N), .ORDER(ORDER), .COEF_CUM(CUM), .COEF_NEG(2'b11)) dut_b (
        .clock(clk), .reset(rst), .in(din), .in_valid(in_valid), .in_ready(in_ready_b),
        .out(out_b), .out_valid(out_valid_b), .out_ready(out_ready), .done(done_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mtap[2];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rev4(input int c);
        return ((c & 1) << 3) | ((c & 2) << 1) | ((c & 4) >> 1) | ((c & 8) >> 3);
    endfunction

    // Reference: walk the 16 SC cycles, pick the tap by cumulative weight, count x > R.
    function automatic int ref_out(input int t0, input int t1, input bit neg);
        int ones = 0;
        int lf   = 1;
        for (int c = 0; c < 16; c++) begin
            int x;
            int r;
            x = (c < int'(CUM[0])) ? t0 : t1;
            if (neg) x = 15 - x;
`ifdef SC_FIR_LFSR_EN
            r = lf;
`else
            r = rev4(c);
`endif
            if (x > r) ones++;
            lf = ((lf << 1) & 15) | (((lf >> 3) ^ (lf >> 2)) & 1);
        end
        return ones;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0;
        tick();
        chk("rst_in_ready", int'(in_ready_a), 0);
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_out", int'(out_a), 0);
        chk("rst_done", int'(done_a), 0);
        rst = 1'b0;
        mtap[0] = 0; mtap[1] = 0;
        tick();
    endtask

    task automatic transact(input int v, input int hold, output int ga, output int gb);
        int waited = 0;
        int cyc;
        int done_cyc = -1;
        in_valid = 1'b1; din = N'(v);
        while (!in_ready_a && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) chk("accept_timeout", waited, 0);
        tick();
        in_valid = 1'b0;
        mtap[1] = mtap[0]; mtap[0] = v;
        cyc = 1;
        while (!out_valid_a && cyc < 40) begin
            if (done_a && done_cyc < 0) done_cyc = cyc;
            tick();
            cyc++;
        end
        chk("latency", cyc, 17);
        chk("done_cycle", done_cyc, 16);
        ga = int'(out_a); gb = int'(out_b);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; din = ~N'(v);
            tick();
            chk("hold_out", int'(out_a), ga);
            chk("hold_valid", int'(out_valid_a), 1);
            chk("hold_in_ready", int'(in_ready_a), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid", int'(out_valid_a), 0);
        chk("release_in_ready", int'(in_ready_a), 1);
        chk("release_out_kept", int'(out_a), ga);
        $display("txn in=%0d hold=%0d out_a=%0d out_b=%0d", v, hold, ga, gb);
    endtask

    typedef struct {
        int din;
        int exp_a;
        int exp_b;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int ga, gb, ea, eb;
        // Hand-derived: out_a = ceil(tap0/2) + floor(tap1/2); out_b uses 15-tap.
        tbl[0] = '{15, 8, 7};
        tbl[1] = '{5, 10, 5};
        tbl[2] = '{5, 5, 10};
        tbl[3] = '{3, 4, 11};
        tbl[4] = '{3, 3, 12};
        tbl[5] = '{0, 1, 14};
        tbl[6] = '{10, 5, 10};

        do_reset();

        for (int i = 0; i < 7; i++) begin
`ifdef SC_FIR_LFSR_EN
            ea = ref_out(tbl[i].din, mtap[0], 1'b0);
            eb = ref_out(tbl[i].din, mtap[0], 1'b1);
`else
            ea = tbl[i].exp_a;
            eb = tbl[i].exp_b;
`endif
            transact(tbl[i].din, (i == 1) ? 5 : 0, ga, gb);
            chk("table_out_a", ga, ea);
            chk("table_out_b", gb, eb);
        end

        // Abort in the middle of a run: no result, delay line cleared.
        in_valid = 1'b1; din = 4'd15;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        chk("abort_in_ready", int'(in_ready_a), 0);
        chk("abort_done", int'(done_a), 0);
        rst = 1'b0;
        mtap[0] = 0; mtap[1] = 0;
        tick();
        chk("abort_valid", int'(out_valid_a), 0);
        chk("abort_out", int'(out_a), 0);
        chk("abort_in_ready_after", int'(in_ready_a), 1);
        transact(15, 0, ga, gb);
        chk("abort_next_out_a", ga, ref_out(15, 0, 1'b0));

        for (int i = 0; i < 20; i++) begin
            int v;
            int hold;
            v = int'($urandom_range(0, 15));
            hold = int'($urandom_range(0, 3));
            transact(v, hold, ga, gb);
            chk("rand_out_a", ga, ref_out(mtap[0], mtap[1], 1'b0));
            chk("rand_out_b", gb, ref_out(mtap[0], mtap[1], 1'b1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
